// File: rtl/clock_set_core.sv
// clock_set_core: time-of-day keeper with a mode/up/down set FSM and 12/24-hour decode.
// Define CLOCK_ALARM_EN to add the alarm registers, the two alarm set states and o_alarm.
module clock_set_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int SUB_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_btn_mode,
  input  logic             i_btn_up,
  input  logic             i_btn_down,
  input  logic             i_fmt12,
  output logic [SUB_W-1:0] o_sub,
  output logic [5:0]       o_sec,
  output logic [5:0]       o_min,
  output logic [4:0]       o_hour,
  output logic             o_pm,
  output logic [2:0]       o_state,
  output logic             o_alarm
);

  localparam int DIV     = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRESC_W = $clog2(DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);
  localparam logic [SUB_W-1:0]   SUB_MAX   = SUB_W'(TICK_HZ - 1);

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_SET_HOUR = 3'd1;
  localparam logic [2:0] ST_SET_MIN  = 3'd2;
  localparam logic [2:0] ST_SET_SEC  = 3'd3;
`ifdef CLOCK_ALARM_EN
  localparam logic [2:0] ST_SET_AL_HOUR = 3'd4;
  localparam logic [2:0] ST_SET_AL_MIN  = 3'd5;
`endif

  function automatic logic [5:0] adj60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] adj24(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  logic [2:0]         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [5:0]         sec_q, sec_d;
  logic [5:0]         min_q, min_d;
  logic [4:0]         hour_q, hour_d;
  logic               mode_prev_q, mode_prev_d;
  logic               up_prev_q, up_prev_d;
  logic               down_prev_q, down_prev_d;
`ifdef CLOCK_ALARM_EN
  logic [4:0]         al_hour_q, al_hour_d;
  logic [5:0]         al_min_q, al_min_d;
  logic               alarm_q, alarm_d;
`endif

  logic mode_edge, up_edge, down_edge, adj_en;
  logic consume, time_runs, enter_set, tick;

  always_comb begin
    mode_edge = i_btn_mode & ~mode_prev_q;
    up_edge   = i_btn_up & ~up_prev_q;
    down_edge = i_btn_down & ~down_prev_q;
    adj_en    = up_edge ^ down_edge;
`ifdef CLOCK_ALARM_EN
    // While the alarm is showing, any fresh button press only acknowledges it.
    consume   = alarm_q & (mode_edge | up_edge | down_edge);
    time_runs = (state_q == ST_RUN) || (state_q == ST_SET_AL_HOUR) ||
                (state_q == ST_SET_AL_MIN);
`else
    consume   = 1'b0;
    time_runs = (state_q == ST_RUN);
`endif
    enter_set = mode_edge & ~consume & (state_q == ST_RUN);
    tick      = time_runs & ~enter_set & (presc_q == PRESC_MAX);

    mode_prev_d = i_btn_mode;
    up_prev_d   = i_btn_up;
    down_prev_d = i_btn_down;
    state_d = state_q;
    presc_d = presc_q;
    sub_d   = sub_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
`ifdef CLOCK_ALARM_EN
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    alarm_d   = alarm_q;
`endif

    if (enter_set) begin
      presc_d = '0;
      sub_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      if (sub_q != SUB_MAX) begin
        sub_d = sub_q + SUB_W'(1);
      end else begin
        sub_d = '0;
        if (sec_q != 6'd59) begin
          sec_d = sec_q + 6'd1;
        end else begin
          sec_d = 6'd0;
          if (min_q != 6'd59) begin
            min_d = min_q + 6'd1;
          end else begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end
        end
      end
    end else if (time_runs) begin
      presc_d = presc_q + PRESC_W'(1);
    end

    // Mode wins over up/down; up and down together cancel out.
    if (consume) begin
`ifdef CLOCK_ALARM_EN
      alarm_d = 1'b0;
`endif
    end else if (mode_edge) begin
      case (state_q)
        ST_RUN:         state_d = ST_SET_HOUR;
        ST_SET_HOUR:    state_d = ST_SET_MIN;
        ST_SET_MIN:     state_d = ST_SET_SEC;
`ifdef CLOCK_ALARM_EN
        ST_SET_SEC:     state_d = ST_SET_AL_HOUR;
        ST_SET_AL_HOUR: state_d = ST_SET_AL_MIN;
`else
        ST_SET_SEC:     state_d = ST_RUN;
`endif
        default:        state_d = ST_RUN;
      endcase
    end else if (adj_en) begin
      case (state_q)
        ST_SET_HOUR:    hour_d = adj24(hour_q, up_edge);
        ST_SET_MIN:     min_d  = adj60(min_q, up_edge);
        ST_SET_SEC:     sec_d  = adj60(sec_q, up_edge);
`ifdef CLOCK_ALARM_EN
        ST_SET_AL_HOUR: al_hour_d = adj24(al_hour_q, up_edge);
        ST_SET_AL_MIN:  al_min_d  = adj60(al_min_q, up_edge);
`endif
        default: ;
      endcase
    end

`ifdef CLOCK_ALARM_EN
    if ((state_q == ST_RUN) && tick && (sub_d == '0) && (sec_d == 6'd0) &&
        (min_d == al_min_q) && (hour_d == al_hour_q)) begin
      alarm_d = 1'b1;
    end
    if (min_d != al_min_q) alarm_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      sub_q       <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
`ifdef CLOCK_ALARM_EN
      al_hour_q   <= '0;
      al_min_q    <= '0;
      alarm_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      sub_q       <= sub_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      mode_prev_q <= mode_prev_d;
      up_prev_q   <= up_prev_d;
      down_prev_q <= down_prev_d;
`ifdef CLOCK_ALARM_EN
      al_hour_q   <= al_hour_d;
      al_min_q    <= al_min_d;
      alarm_q     <= alarm_d;
`endif
    end
  end

  always_comb begin
    o_hour = hour_q;
    if (i_fmt12) begin
      if (hour_q == 5'd0)       o_hour = 5'd12;
      else if (hour_q > 5'd12)  o_hour = hour_q - 5'd12;
    end
  end

  assign o_sub   = sub_q;
  assign o_sec   = sec_q;
  assign o_min   = min_q;
  assign o_pm    = (hour_q >= 5'd12);
  assign o_state = state_q;
`ifdef CLOCK_ALARM_EN
  assign o_alarm = alarm_q;
`else
  assign o_alarm = 1'b0;
`endif

endmodule
